// File: rtl/br_dump_reader_pkg.sv
// Shared core definitions for the register-bank dump reader:
// bank geometry and the reader's state encoding.
package br_dump_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/br_dump_reader.sv
// Register-bank dump reader: walks an inclusive, possibly wrapping index
// range over the bank's asynchronous read port and streams each sampled
// word out on a valid/ready channel, pulsing done after the final beat.
module br_dump_reader
    import br_dump_reader_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    dump_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] ptr_next;

    // Next index wraps naturally at 2**ADDR_W, which gives the 31->0 wrap for free.
    assign ptr_next = ptr + ADDR_W'(1);

    // Dump sequencer: ra is registered so it already points at ptr for the whole READ cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            last_q  <= '0;
            ra      <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ptr    <= first_reg;
                        last_q <= last_reg;
                        ra     <= first_reg;
                        busy   <= 1'b1;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    m_data  <= rd;
                    m_idx   <= ptr;
                    m_last  <= (ptr == last_q);
                    m_valid <= 1'b1;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ptr   <= ptr_next;
                            ra    <= ptr_next;
                            state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
